// File: rtl/rgb_duty_scheduler_if.sv
// Bus between the temperature sources and the duty scheduler feeding the RGB PWM stage.
// The master drives the sample and mode inputs; the scheduler (slave) returns the duty command.
interface rgb_duty_scheduler_if;
  logic        enable;
  logic [15:0] temp_data;
  logic        temp_valid;
  logic [12:0] manualSwitch;
  logic [6:0]  duty;
  logic        duty_valid;
  logic [1:0]  zone;
  logic        stale;

  modport master (
    output enable, temp_data, temp_valid, manualSwitch,
    input  duty, duty_valid, zone, stale
  );

  modport slave (
    input  enable, temp_data, temp_valid, manualSwitch,
    output duty, duty_valid, zone, stale
  );
endinterface

// File: rtl/rgb_duty_scheduler.sv
// Temperature-zone classifier with hysteresis and a slow duty ramp for the RGB PWM stage.
// A sensor timeout forces the failsafe duty; an enable edge aborts and re-arms the controller.
module rgb_duty_scheduler #(
  parameter int          HOT_TH        = 30,
  parameter int          HYST          = 2,
  parameter int unsigned DUTY_COLD     = 25,
  parameter int unsigned DUTY_MILD     = 50,
  parameter int unsigned DUTY_HOT      = 80,
  parameter int unsigned FAILSAFE_DUTY = 100,
  parameter int unsigned RAMP_DIV      = 1000,
  parameter int unsigned TIMEOUT       = 50_000_000
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  rgb_duty_scheduler_if.slave   bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(RAMP_DIV + 1);

  localparam logic [1:0] Z_NONE = 2'd0;
  localparam logic [1:0] Z_COLD = 2'd1;
  localparam logic [1:0] Z_MILD = 2'd2;
  localparam logic [1:0] Z_HOT  = 2'd3;

  // Thresholds held at 10 bits so HOT_TH-HYST and sign compares cannot overflow
  localparam logic signed [9:0] HOT_C    = 10'(HOT_TH);
  localparam logic signed [9:0] HYST_C   = 10'(HYST);
  localparam logic signed [9:0] HOT_LO_C = 10'(HOT_TH - HYST);
  localparam logic [6:0]        FAIL_C   = 7'(FAILSAFE_DUTY);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_CLASSIFY, S_RAMP} state_e;

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic          pend_vld_q, pend_vld_d;
  logic [8:0]    pend_t_q, pend_t_d;
  logic [8:0]    t_q, t_d;
  logic [1:0]    zone_q, zone_d;
  logic [6:0]    target_q, target_d;
  logic [6:0]    duty_q, duty_d;
  logic          duty_valid_q, duty_valid_d;
  logic          stale_q, stale_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] div_q, div_d;

  logic          src_switch;
  logic          sens_smp;
  logic          tmo_fire;
  logic [8:0]    sens_t;
  logic [8:0]    man_t;
  logic signed [9:0] t_ext;
  logic          unused_bits;

  assign sens_t      = bus.temp_data[15:7];
  assign man_t       = bus.manualSwitch[12:4];
  assign t_ext       = $signed({t_q[8], t_q});
  assign unused_bits = ^{bus.temp_data[6:0], bus.manualSwitch[3:0]};

  function automatic logic [1:0] classify(input logic [1:0] z, input logic signed [9:0] t);
    logic [1:0] nz;
    nz = z;
    case (z)
      Z_COLD:  if (t > HOT_C) nz = Z_HOT;
               else if (t >= HYST_C) nz = Z_MILD;
      Z_MILD:  if (t > HOT_C) nz = Z_HOT;
               else if (t[9]) nz = Z_COLD;
      Z_HOT:   if (t[9]) nz = Z_COLD;
               else if (t >= HYST_C && t <= HOT_LO_C) nz = Z_MILD;
      default: if (t[9]) nz = Z_COLD;
               else if (t > HOT_C) nz = Z_HOT;
               else nz = Z_MILD;
    endcase
    return nz;
  endfunction

  function automatic logic [6:0] zone_duty(input logic [1:0] z);
    case (z)
      Z_COLD:  return 7'(DUTY_COLD);
      Z_MILD:  return 7'(DUTY_MILD);
      Z_HOT:   return 7'(DUTY_HOT);
      default: return FAIL_C;
    endcase
  endfunction

  // Next-state logic: source switch beats timeout, timeout beats the normal sequence
  always_comb begin
    state_d      = state_q;
    en_d         = bus.enable;
    pend_vld_d   = pend_vld_q;
    pend_t_d     = pend_t_q;
    t_d          = t_q;
    zone_d       = zone_q;
    target_d     = target_q;
    duty_d       = duty_q;
    stale_d      = stale_q;
    tmo_d        = tmo_q;
    div_d        = div_q;
    tmo_fire     = 1'b0;
    src_switch   = bus.enable != en_q;
    sens_smp     = bus.enable && bus.temp_valid;

    if (src_switch) begin
      pend_vld_d = 1'b0;
      tmo_d      = '0;
      zone_d     = Z_NONE;
      stale_d    = bus.enable;
      state_d    = S_IDLE;
    end else begin
      if (bus.enable) begin
        if (bus.temp_valid) begin
          tmo_d   = '0;
          stale_d = 1'b0;
        end else if (tmo_q != TW'(TIMEOUT - 1)) begin
          tmo_d    = tmo_q + TW'(1);
          tmo_fire = tmo_q == TW'(TIMEOUT - 2);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (pend_vld_q) begin
            t_d        = pend_t_q;
            pend_vld_d = 1'b0;
            state_d    = S_LATCH;
          end else if (sens_smp) begin
            t_d     = sens_t;
            state_d = S_LATCH;
          end else if (!bus.enable) begin
            t_d     = man_t;
            state_d = S_LATCH;
          end
        end
        S_LATCH: state_d = S_CLASSIFY;
        S_CLASSIFY: begin
          zone_d   = classify(zone_q, t_ext);
          target_d = stale_d ? FAIL_C : zone_duty(zone_d);
          div_d    = '0;
          state_d  = (target_d != duty_q) ? S_RAMP : S_IDLE;
        end
        S_RAMP: begin
          if (duty_q == target_q) begin
            state_d = S_IDLE;
          end else if (div_q == DW'(RAMP_DIV - 1)) begin
            div_d  = '0;
            duty_d = (duty_q < target_q) ? duty_q + 7'd1 : duty_q - 7'd1;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A sensor sample that is not consumed right now waits in the one-deep pending slot
      if (sens_smp && !(state_q == S_IDLE && !pend_vld_q)) begin
        pend_vld_d = 1'b1;
        pend_t_d   = sens_t;
      end

      if (tmo_fire) begin
        stale_d    = 1'b1;
        zone_d     = Z_NONE;
        target_d   = FAIL_C;
        pend_vld_d = 1'b0;
        if (state_q != S_RAMP) div_d = '0;
        state_d    = (duty_q != FAIL_C) ? S_RAMP : S_IDLE;
      end
    end

    duty_valid_d = (state_d == S_IDLE) && (duty_d == target_d);
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b1;
      pend_vld_q   <= 1'b0;
      pend_t_q     <= '0;
      t_q          <= '0;
      zone_q       <= Z_NONE;
      target_q     <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      stale_q      <= 1'b1;
      tmo_q        <= '0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      pend_vld_q   <= pend_vld_d;
      pend_t_q     <= pend_t_d;
      t_q          <= t_d;
      zone_q       <= zone_d;
      target_q     <= target_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      stale_q      <= stale_d;
      tmo_q        <= tmo_d;
      div_q        <= div_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.zone       = zone_q;
  assign bus.stale      = stale_q;

endmodule

// File: tb/tb_rgb_duty_scheduler.sv
// Directed bench for rgb_duty_scheduler with short ramp divider and timeout.
// Expected values are hand-derived from the zone/ramp rules for RAMP_DIV=3, TIMEOUT=400.
module tb_rgb_duty_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  rgb_duty_scheduler_if bus ();

  rgb_duty_scheduler #(
    .RAMP_DIV (3),
    .TIMEOUT  (400)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [8:0] t);
    bus.temp_data  = {t, 7'd0};
    bus.temp_valid = 1'b1;
    tick(1);
    bus.temp_valid = 1'b0;
  endtask

  task automatic wait_settle(input string tag, input int budget);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      if (bus.duty_valid === 1'b1) ok = 1'b1;
      else begin
        tick(1);
        n++;
      end
    end
    check(tag, 16'(ok), 16'd1);
  endtask

  task automatic wait_zone(input string tag, input logic [1:0] z, input int budget);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      if (bus.zone === z) ok = 1'b1;
      else begin
        tick(1);
        n++;
      end
    end
    check(tag, 16'(ok), 16'd1);
  endtask

  task automatic wait_stale(input string tag, input int budget);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      if (bus.stale === 1'b1) ok = 1'b1;
      else begin
        tick(1);
        n++;
      end
    end
    check(tag, 16'(ok), 16'd1);
  endtask

  initial begin
    reset_n          = 1'b1;
    bus.enable       = 1'b1;
    bus.temp_data    = '0;
    bus.temp_valid   = 1'b0;
    bus.manualSwitch = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_duty",  16'(bus.duty), 16'd0);
    check("rst_dv",    16'(bus.duty_valid), 16'd0);
    check("rst_zone",  16'(bus.zone), 16'd0);
    check("rst_stale", 16'(bus.stale), 16'd1);
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // T=31 -> HOT, ramp 0 -> 80 at 3 clocks per step
    pulse(9'd31);
    tick(2);
    check("hot_zone",  16'(bus.zone), 16'd3);
    check("hot_stale", 16'(bus.stale), 16'd0);
    check("hot_d0",    16'(bus.duty), 16'd0);
    tick(30);
    check("hot_d10",   16'(bus.duty), 16'd10);
    tick(210);
    check("hot_d80",   16'(bus.duty), 16'd80);
    check("hot_dv0",   16'(bus.duty_valid), 16'd0);
    tick(1);
    check("hot_dv1",   16'(bus.duty_valid), 16'd1);

    // Hysteresis on the way down from HOT
    pulse(9'd29);
    tick(2);
    check("t29_zone", 16'(bus.zone), 16'd3);
    wait_settle("t29_settle", 10);
    check("t29_duty", 16'(bus.duty), 16'd80);
    pulse(9'd28);
    tick(2);
    check("t28_zone", 16'(bus.zone), 16'd2);
    wait_settle("t28_settle", 150);
    check("t28_duty", 16'(bus.duty), 16'd50);

    // MILD -> COLD, then COLD hysteresis
    pulse(9'h1FF);
    tick(2);
    check("tm1_zone", 16'(bus.zone), 16'd1);
    wait_settle("tm1_settle", 150);
    check("tm1_duty", 16'(bus.duty), 16'd25);
    pulse(9'd1);
    tick(2);
    check("t1_zone", 16'(bus.zone), 16'd1);
    wait_settle("t1_settle", 10);
    check("t1_duty", 16'(bus.duty), 16'd25);
    pulse(9'd2);
    tick(2);
    check("t2_zone", 16'(bus.zone), 16'd2);
    wait_settle("t2_settle", 150);
    check("t2_duty", 16'(bus.duty), 16'd50);

    // Sensor timeout -> failsafe, then recovery
    wait_stale("tmo_stale", 450);
    check("tmo_zone", 16'(bus.zone), 16'd0);
    tick(3);
    wait_settle("tmo_settle", 250);
    check("tmo_duty", 16'(bus.duty), 16'd100);
    pulse(9'd10);
    check("rec_stale", 16'(bus.stale), 16'd0);
    tick(2);
    check("rec_zone", 16'(bus.zone), 16'd2);
    wait_settle("rec_settle", 250);
    check("rec_duty", 16'(bus.duty), 16'd50);

    // Manual source T=31, then switch back to sensor
    bus.enable       = 1'b0;
    bus.manualSwitch = 13'h1F0;
    tick(1);
    check("man_sw_zone",  16'(bus.zone), 16'd0);
    check("man_sw_stale", 16'(bus.stale), 16'd0);
    tick(3);
    check("man_zone", 16'(bus.zone), 16'd3);
    wait_settle("man_settle", 150);
    check("man_duty", 16'(bus.duty), 16'd80);
    bus.enable = 1'b1;
    tick(1);
    check("sw_zone",  16'(bus.zone), 16'd0);
    check("sw_stale", 16'(bus.stale), 16'd1);
    check("sw_duty",  16'(bus.duty), 16'd80);
    tick(10);
    check("sw_hold",  16'(bus.duty), 16'd80);

    // Samples during RAMP: only the newest is processed afterwards
    pulse(9'd10);
    tick(2);
    check("pd_zone",  16'(bus.zone), 16'd2);
    check("pd_stale", 16'(bus.stale), 16'd0);
    tick(5);
    pulse(9'd31);
    tick(3);
    pulse(9'h1FB);
    tick(1);
    check("pd_mid_zone", 16'(bus.zone), 16'd2);
    check("pd_mid_duty", 16'(bus.duty), 16'd77);
    wait_zone("pd_cold_wait", 2'd1, 300);
    wait_settle("pd_settle", 200);
    check("pd_zone_f", 16'(bus.zone), 16'd1);
    check("pd_duty_f", 16'(bus.duty), 16'd25);

    // Asynchronous reset in the middle of a ramp
    pulse(9'd31);
    tick(2);
    check("mr_zone", 16'(bus.zone), 16'd3);
    tick(20);
    check("mr_duty", 16'(bus.duty), 16'd31);
    #2 reset_n = 1'b0;
    #1;
    check("mr_rst_duty",  16'(bus.duty), 16'd0);
    check("mr_rst_zone",  16'(bus.zone), 16'd0);
    check("mr_rst_stale", 16'(bus.stale), 16'd1);
    check("mr_rst_dv",    16'(bus.duty_valid), 16'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
